// File: rtl/vga_pkg.sv
// vga_pkg: 800x600 timing constants, colour width, background colour and piece descriptor type
package vga_pkg;
  localparam int HBP = 216;
  localparam int HFP = 1016;
  localparam int VBP = 27;
  localparam int VFP = 627;
  localparam int COLOR_W = 12;
  localparam logic [COLOR_W-1:0] BG_COLOR = 12'h000;
  typedef struct packed {
    logic               en;
    logic [9:0]         x0;
    logic [9:0]         y0;
    logic [9:0]         x1;
    logic [9:0]         y1;
    logic [COLOR_W-1:0] color;
  } piece_desc_t;
endpackage

// File: rtl/vga_piece_hit.sv
// vga_piece_hit: inclusive rectangle test of pixel (x,y) against one piece -> hit (plus on_edge under VGA_PIECE_BORDER_EN)
module vga_piece_hit (
  input  logic       en,
  input  logic [9:0] x0,
  input  logic [9:0] x1,
  input  logic [9:0] y0,
  input  logic [9:0] y1,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit
`ifdef VGA_PIECE_BORDER_EN
  ,
  output logic       on_edge
`endif
);
  assign hit = en && x0 <= x && x <= x1 && y0 <= y && y <= y1;
`ifdef VGA_PIECE_BORDER_EN
  assign on_edge = x == x0 || x == x1 || y == y0 || y == y1;
`endif
endmodule

// File: rtl/vga_piece_renderer.sv
// vga_piece_renderer: 3-stage rgb pipeline over hc/vc/vidon/syncs, shadow descriptors via wr_valid/wr_ready committed on vsync fall (frame_commit); VGA_PIECE_BORDER_EN inverts piece edge pixels
module vga_piece_renderer #(
  parameter int                 NPIECE   = 7,
  parameter int                 HBP      = vga_pkg::HBP,
  parameter int                 VBP      = vga_pkg::VBP,
  parameter int                 COLOR_W  = vga_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR = vga_pkg::BG_COLOR
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [10:0]        hc,
  input  logic [10:0]        vc,
  input  logic               vidon,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_idx,
  input  logic               wr_en,
  input  logic [9:0]         wr_x0,
  input  logic [9:0]         wr_x1,
  input  logic [9:0]         wr_y0,
  input  logic [9:0]         wr_y1,
  input  logic [COLOR_W-1:0] wr_color,
  output logic               frame_commit,
  output logic [COLOR_W-1:0] rgb,
  output logic               hsync_out,
  output logic               vsync_out
);
  import vga_pkg::piece_desc_t;
  piece_desc_t act_q [NPIECE];
  piece_desc_t act_d [NPIECE];
  piece_desc_t shd_q [NPIECE];
  piece_desc_t shd_d [NPIECE];
  logic dirty_q, dirty_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [2:0] sb1_q, sb1_d, sb2_q, sb2_d;
  logic [1:0] sb3_q, sb3_d;
  logic [NPIECE-1:0] hit_q, hit_d;
`ifdef VGA_PIECE_BORDER_EN
  logic [NPIECE-1:0] edge_q, edge_d;
`endif
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic commit;
  assign commit       = sb1_q[0] && !vsync_in && dirty_q;
  assign wr_ready     = !commit;
  assign frame_commit = commit;
  assign rgb          = rgb_q;
  assign hsync_out    = sb3_q[1];
  assign vsync_out    = sb3_q[0];
  for (genvar i = 0; i < NPIECE; i++) begin : g_hit
    vga_piece_hit u_hit (
      .en(act_q[i].en),
      .x0(act_q[i].x0),
      .x1(act_q[i].x1),
      .y0(act_q[i].y0),
      .y1(act_q[i].y1),
      .x(x_q),
      .y(y_q),
      .hit(hit_d[i])
`ifdef VGA_PIECE_BORDER_EN
      ,
      .on_edge(edge_d[i])
`endif
    );
  end
  always_comb begin
    x_d = 10'(hc - 11'(HBP + 1));
    y_d = 10'(vc - 11'(VBP + 1));
    sb1_d = {vidon, hsync_in, vsync_in};
    sb2_d = sb1_q;
    sb3_d = sb2_q[1:0];
    rgb_d = BG_COLOR;
    for (int i = NPIECE - 1; i >= 0; i--)
`ifdef VGA_PIECE_BORDER_EN
      if (hit_q[i]) rgb_d = edge_q[i] ? ~act_q[i].color : act_q[i].color;
`else
      if (hit_q[i]) rgb_d = act_q[i].color;
`endif
    if (!sb2_q[2]) rgb_d = '0;
    shd_d = shd_q;
    act_d = act_q;
    dirty_d = dirty_q;
    if (wr_valid && wr_ready && 32'(wr_idx) < NPIECE) begin
      shd_d[wr_idx] = '{en: wr_en, x0: wr_x0, y0: wr_y0, x1: wr_x1, y1: wr_y1, color: wr_color};
      dirty_d = 1'b1;
    end
    if (commit) begin
      act_d = shd_q;
      dirty_d = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (!clr) begin
      for (int i = 0; i < NPIECE; i++) begin
        act_q[i] <= '0;
        shd_q[i] <= '0;
      end
      dirty_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      sb1_q <= '0;
      sb2_q <= '0;
      sb3_q <= '0;
      hit_q <= '0;
`ifdef VGA_PIECE_BORDER_EN
      edge_q <= '0;
`endif
      rgb_q <= '0;
    end else begin
      act_q <= act_d;
      shd_q <= shd_d;
      dirty_q <= dirty_d;
      x_q <= x_d;
      y_q <= y_d;
      sb1_q <= sb1_d;
      sb2_q <= sb2_d;
      sb3_q <= sb3_d;
      hit_q <= hit_d;
`ifdef VGA_PIECE_BORDER_EN
      edge_q <= edge_d;
`endif
      rgb_q <= rgb_d;
    end
endmodule

// File: tb/tb_vga_piece_renderer.sv
// tb_vga_piece_renderer: self-checking bench with a frame-level reference model of the piece renderer
`timescale 1ns/1ps
module tb_vga_piece_renderer;
  import vga_pkg::*;
`ifdef VGA_PIECE_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  logic clk = 1'b0;
  logic clr;
  logic [10:0] hc, vc;
  logic vidon, hsync_in, vsync_in;
  logic wr_valid, wr_ready, wr_en;
  logic [2:0] wr_idx;
  logic [9:0] wr_x0, wr_x1, wr_y0, wr_y1;
  logic [11:0] wr_color;
  logic frame_commit, hsync_out, vsync_out;
  logic [11:0] rgb;
  int errs = 0;
  int checks = 0;
  piece_desc_t m_act [7];
  piece_desc_t m_shd [7];
  bit m_dirty, m_vs_prev, exp_commit, fc_seen, rdy_seen;
  bit cur_vs = 1'b0;
  logic [13:0] exp_q [$];

  vga_piece_renderer dut (
    .clk(clk), .clr(clr), .hc(hc), .vc(vc), .vidon(vidon),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_en(wr_en),
    .wr_x0(wr_x0), .wr_x1(wr_x1), .wr_y0(wr_y0), .wr_y1(wr_y1), .wr_color(wr_color),
    .frame_commit(frame_commit), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  // Colour the spec's rules give for pixel (x,y): first enabled piece in index order containing it.
  function automatic logic [11:0] ref_pixel(input int x, input int y, input bit vid);
    if (!vid) return 12'h000;
    for (int i = 0; i < 7; i++)
      if (m_act[i].en && x >= int'(m_act[i].x0) && x <= int'(m_act[i].x1) &&
          y >= int'(m_act[i].y0) && y <= int'(m_act[i].y1)) begin
        if (BORDER && (x == int'(m_act[i].x0) || x == int'(m_act[i].x1) ||
                       y == int'(m_act[i].y0) || y == int'(m_act[i].y1)))
          return ~m_act[i].color;
        return m_act[i].color;
      end
    return BG_COLOR;
  endfunction

  // One pixel clock: drive inputs, observe handshake outputs before the edge, advance the model.
  task automatic step(input int h, input int v, input bit vid, input bit hs, input bit vs);
    hc = 11'(h);
    vc = 11'(v);
    vidon = vid;
    hsync_in = hs;
    vsync_in = vs;
    #1;
    fc_seen = frame_commit;
    rdy_seen = wr_ready;
    if (!clr) begin
      foreach (m_act[i]) begin
        m_act[i] = '0;
        m_shd[i] = '0;
      end
      m_dirty = 1'b0;
      m_vs_prev = 1'b0;
      exp_q.push_back(14'd0);
    end else begin
      exp_commit = m_vs_prev && !vs && m_dirty;
      if (wr_valid && !exp_commit && wr_idx < 3'd7) begin
        m_shd[wr_idx] = '{en: wr_en, x0: wr_x0, y0: wr_y0, x1: wr_x1, y1: wr_y1, color: wr_color};
        m_dirty = 1'b1;
      end
      if (exp_commit) begin
        m_act = m_shd;
        m_dirty = 1'b0;
      end
      m_vs_prev = vs;
      exp_q.push_back({ref_pixel(h - 217, v - 28, vid), hs, vs});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 1'b0, 1'b0, cur_vs);
  endtask

  task automatic write_piece(input logic [2:0] idx, input bit en, input int x0, input int y0,
                             input int x1, input int y1, input logic [11:0] c);
    bit done = 1'b0;
    wr_idx = idx;
    wr_en = en;
    wr_x0 = 10'(x0);
    wr_y0 = 10'(y0);
    wr_x1 = 10'(x1);
    wr_y1 = 10'(y1);
    wr_color = c;
    wr_valid = 1'b1;
    for (int k = 0; k < 4 && !done; k++) begin
      step(0, 0, 1'b0, 1'b0, cur_vs);
      done = rdy_seen;
    end
    wr_valid = 1'b0;
    if (!done) begin
      errs++;
      $display("FAIL write_accept: idx %0d never saw wr_ready=1", idx);
    end
    checks++;
  endtask

  task automatic vsync_fall();
    step(0, 0, 1'b0, 1'b0, 1'b1);
    cur_vs = 1'b0;
    step(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic probe(input int x, input int y, input bit vid);
    step(x + 217, y + 28, vid, 1'b0, cur_vs);
    idle(2);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    step(300, 300, 1'b1, 1'b1, 1'b1);
    step(300, 300, 1'b1, 1'b1, 1'b1);
    checks += 5;
    if (rgb !== 12'h000) begin errs++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    if (hsync_out !== 1'b0) begin errs++; $display("FAIL reset_hsync: got %b want 0", hsync_out); end
    if (vsync_out !== 1'b0) begin errs++; $display("FAIL reset_vsync: got %b want 0", vsync_out); end
    if (frame_commit !== 1'b0) begin errs++; $display("FAIL reset_commit: got %b want 0", frame_commit); end
    if (wr_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
    clr = 1'b1;
    cur_vs = 1'b0;
    idle(3);
  endtask

  task automatic test_single_piece();
    logic [11:0] corner = BORDER ? 12'h0FF : 12'hF00;
    write_piece(3'd0, 1'b1, 10, 20, 19, 29, 12'hF00);
    vsync_fall();
    checks++;
    if (fc_seen !== 1'b1) begin errs++; $display("FAIL single_commit: got %b want 1", fc_seen); end
    idle(1);
    checks++;
    if (fc_seen !== 1'b0) begin errs++; $display("FAIL single_commit_once: got %b want 0", fc_seen); end
    step(227, 48, 1'b1, 1'b0, 1'b0);
    idle(1);
    checks++;
    if (rgb !== 12'h000) begin errs++; $display("FAIL single_early: got %h want 000", rgb); end
    idle(1);
    checks++;
    if (rgb !== corner) begin errs++; $display("FAIL single_hit: got %h want %h", rgb, corner); end
    step(226, 48, 1'b1, 1'b0, 1'b0);
    idle(2);
    checks++;
    if (rgb !== BG_COLOR) begin errs++; $display("FAIL single_left_miss: got %h want %h", rgb, BG_COLOR); end
  endtask

  task automatic test_priority();
    write_piece(3'd0, 1'b1, 0, 0, 99, 99, 12'h00F);
    write_piece(3'd3, 1'b1, 50, 50, 149, 149, 12'h0F0);
    vsync_fall();
    checks++;
    if (fc_seen !== 1'b1) begin errs++; $display("FAIL prio_commit: got %b want 1", fc_seen); end
    probe(60, 60, 1'b1);
    checks++;
    if (rgb !== 12'h00F) begin errs++; $display("FAIL prio_overlap: got %h want 00F", rgb); end
    probe(120, 120, 1'b1);
    checks++;
    if (rgb !== 12'h0F0) begin errs++; $display("FAIL prio_low_only: got %h want 0F0", rgb); end
    probe(200, 200, 1'b1);
    checks++;
    if (rgb !== 12'h000) begin errs++; $display("FAIL prio_bg: got %h want 000", rgb); end
  endtask

  task automatic test_tear_free();
    wr_idx = 3'd0;
    wr_en = 1'b1;
    wr_x0 = 10'd0;
    wr_y0 = 10'd0;
    wr_x1 = 10'd99;
    wr_y1 = 10'd99;
    wr_color = 12'hF0F;
    wr_valid = 1'b1;
    step(222, 300, 1'b1, 1'b0, 1'b0);
    wr_valid = 1'b0;
    checks++;
    if (rdy_seen !== 1'b1) begin errs++; $display("FAIL tear_ready: got %b want 1", rdy_seen); end
    probe(5, 5, 1'b1);
    checks++;
    if (rgb !== 12'h00F) begin errs++; $display("FAIL tear_old_colour: got %h want 00F", rgb); end
    vsync_fall();
    checks++;
    if (fc_seen !== 1'b1) begin errs++; $display("FAIL tear_commit: got %b want 1", fc_seen); end
    probe(5, 5, 1'b1);
    checks++;
    if (rgb !== 12'hF0F) begin errs++; $display("FAIL tear_new_colour: got %h want F0F", rgb); end
    vsync_fall();
    checks++;
    if (fc_seen !== 1'b0) begin errs++; $display("FAIL tear_clean_no_commit: got %b want 0", fc_seen); end
  endtask

  task automatic test_handshake();
    write_piece(3'd1, 1'b1, 300, 300, 309, 309, 12'hFFF);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    cur_vs = 1'b0;
    wr_idx = 3'd2;
    wr_en = 1'b1;
    wr_x0 = 10'd400;
    wr_y0 = 10'd400;
    wr_x1 = 10'd409;
    wr_y1 = 10'd409;
    wr_color = 12'h0AA;
    wr_valid = 1'b1;
    step(0, 0, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (rdy_seen !== 1'b0) begin errs++; $display("FAIL hs_ready_on_commit: got %b want 0", rdy_seen); end
    if (fc_seen !== 1'b1) begin errs++; $display("FAIL hs_commit: got %b want 1", fc_seen); end
    step(0, 0, 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b0;
    checks++;
    if (rdy_seen !== 1'b1) begin errs++; $display("FAIL hs_ready_after: got %b want 1", rdy_seen); end
    probe(405, 405, 1'b1);
    checks++;
    if (rgb !== 12'h000) begin errs++; $display("FAIL hs_shadow_only: got %h want 000", rgb); end
    probe(305, 305, 1'b1);
    checks++;
    if (rgb !== 12'hFFF) begin errs++; $display("FAIL hs_committed: got %h want FFF", rgb); end
    vsync_fall();
    checks++;
    if (fc_seen !== 1'b1) begin errs++; $display("FAIL hs_late_commit: got %b want 1", fc_seen); end
    probe(405, 405, 1'b1);
    checks++;
    if (rgb !== 12'h0AA) begin errs++; $display("FAIL hs_late_write: got %h want 0AA", rgb); end
    write_piece(3'd7, 1'b1, 0, 0, 1023, 1023, 12'h123);
    vsync_fall();
    probe(700, 500, 1'b1);
    checks++;
    if (rgb !== 12'h000) begin errs++; $display("FAIL hs_idx7_dropped: got %h want 000", rgb); end
  endtask

  task automatic test_blank_edges();
    bit hsq [24];
    logic [11:0] corner = BORDER ? 12'h0FF : 12'hF00;
    probe(5, 5, 1'b0);
    checks++;
    if (rgb !== 12'h000) begin errs++; $display("FAIL blank_vidon0: got %h want 000", rgb); end
    write_piece(3'd4, 1'b1, 50, 500, 40, 510, 12'h555);
    write_piece(3'd0, 1'b1, 10, 20, 19, 29, 12'hF00);
    vsync_fall();
    probe(45, 505, 1'b1);
    checks++;
    if (rgb !== 12'h000) begin errs++; $display("FAIL empty_mid: got %h want 000", rgb); end
    probe(50, 505, 1'b1);
    checks++;
    if (rgb !== 12'h000) begin errs++; $display("FAIL empty_x0: got %h want 000", rgb); end
    probe(10, 25, 1'b1);
    checks++;
    if (rgb !== corner) begin errs++; $display("FAIL border_edge: got %h want %h", rgb, corner); end
    probe(15, 25, 1'b1);
    checks++;
    if (rgb !== 12'hF00) begin errs++; $display("FAIL border_inside: got %h want F00", rgb); end
    for (int i = 0; i < 24; i++) begin
      hsq[i] = 1'($urandom);
      step(0, 0, 1'b0, hsq[i], 1'b0);
      if (i >= 2) begin
        checks++;
        if (hsync_out !== hsq[i-2]) begin
          errs++;
          $display("FAIL hsync_delay[%0d]: got %b want %b", i, hsync_out, hsq[i-2]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [13:0] want;
    for (int p = 0; p < 7; p++)
      write_piece(3'(p), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 40), $urandom_range(0, 40),
                  $urandom_range(0, 40), $urandom_range(0, 40), 12'($urandom));
    vsync_fall();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 45) + 217, $urandom_range(0, 45) + 28, $urandom_range(0, 4) != 0,
           1'($urandom), 1'b0);
      if (i >= 2) begin
        want = exp_q[exp_q.size() - 3];
        checks++;
        if ({rgb, hsync_out, vsync_out} !== want) begin
          errs++;
          $display("FAIL random_pixel[%0d]: got %h/%b/%b want %h/%b/%b", i, rgb, hsync_out, vsync_out,
                   want[13:2], want[1], want[0]);
        end
      end
    end
  endtask

  initial begin
    clr = 1'b0;
    hc = '0;
    vc = '0;
    vidon = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    wr_valid = 1'b0;
    wr_idx = '0;
    wr_en = 1'b0;
    wr_x0 = '0;
    wr_x1 = '0;
    wr_y0 = '0;
    wr_y1 = '0;
    wr_color = '0;
    test_reset();
    test_single_piece();
    test_priority();
    test_tear_free();
    test_handshake();
    test_blank_edges();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/vga_piece_renderer.md
Name: vga_piece_renderer

Overview:
- Pixel-colour stage directly downstream of the 800x600 VGA timing generator.
- Consumes hc/vc/vidon/hsync/vsync and renders up to NPIECE axis-aligned, prioritised, coloured rectangles (tangram piece bounding regions) over a background colour.
- Produces registered RGB plus hsync/vsync delayed to match the pipeline.
- Piece descriptors are written through a valid/ready port into shadow registers and committed atomically at frame start, so there is no tearing.

Parameters:
- NPIECE, 7, number of pieces; index 0 has the highest priority.
- HBP, 216, hc value immediately before the first visible column.
- VBP, 27, vc value immediately before the first visible line.
- COLOR_W, 12, RGB width (4:4:4).
- BG_COLOR, 12'h000, colour for visible pixels not covered by any piece.

Ports:
- clk  in  1  pixel clock (40 MHz)
- clr  in  1  synchronous reset, active-low
- hc  in  11  horizontal count from the timing generator
- vc  in  11  vertical count from the timing generator
- vidon  in  1  visible-region flag
- hsync_in  in  1  horizontal sync from the timing generator
- vsync_in  in  1  vertical sync from the timing generator
- wr_valid  in  1  descriptor write request
- wr_ready  out  1  descriptor write accepted when high with wr_valid
- wr_idx  in  3  piece index; writes with index >= NPIECE are accepted and dropped
- wr_en  in  1  piece visible flag
- wr_x0, wr_x1  in  10  inclusive column bounds
- wr_y0, wr_y1  in  10  inclusive row bounds
- wr_color  in  COLOR_W  piece colour
- frame_commit  out  1  one-cycle pulse when shadow is copied to active
- rgb  out  COLOR_W  pixel colour
- hsync_out  out  1  hsync delayed 3 cycles
- vsync_out  out  1  vsync delayed 3 cycles

Behaviour:
- Reset (clr=0 at a clk edge):
  - all active and shadow entries: en=0, bounds 0, colour 0.
  - dirty=0, rgb=0, hsync_out=0, vsync_out=0, frame_commit=0, wr_ready=1.
  - pipeline valid bits cleared.
  - Reset mid-frame discards in-flight pixels and pending writes.
- Coordinates: x = hc-(HBP+1), y = vc-(VBP+1), truncated to 10 bits; meaningful only when vidon=1.
- Pipeline, latency 3 cycles from an hc/vc sample to rgb:
  - S1: register x, y, vidon, hsync_in, vsync_in.
  - S2: per-piece hit = en && x0<=x<=x1 && y0<=y<=y1, unsigned compares against the ACTIVE set. Register the hit vector and the S1 sideband.
  - S3: priority select, lowest hit index wins.
    - rgb = that piece's colour.
    - no hit: rgb = BG_COLOR.
    - vidon=0: rgb = 0.
  - hsync_out/vsync_out are the S3 copies of the syncs.
- Bounds edge cases: x0>x1 or y0>y1 is an empty piece and never hits. A rectangle with x0=x1 and y0=y1 covers exactly one pixel.
- Write handshake:
  - A write transfers on a cycle with wr_valid && wr_ready. It updates shadow[wr_idx] and sets dirty=1.
  - wr_ready=0 only on the commit cycle; a write presented then is held by the producer and accepted next cycle.
- Commit:
  - vsync_fall = registered vsync_in==1 and current vsync_in==0.
  - On a vsync_fall cycle with dirty=1: active <= shadow (all entries), dirty <= 0, frame_commit=1 for that cycle.
  - vsync_fall with dirty=0: no copy and no pulse.
  - Commit always happens outside the visible region, so no frame mixes old and new descriptors.
- Simultaneous events: a write and vsync_fall in the same cycle cannot both happen, because wr_ready=0 during commit.

Optional Feature:
- Macro: VGA_PIECE_BORDER_EN.
- Defined: if the winning piece's hit pixel lies on its rectangle edge (x==x0, x==x1, y==y0 or y==y1), rgb = bitwise NOT of that piece's colour. Latency is unchanged at 3.
- Undefined: plain fill only, and no edge-compare logic is synthesised.

Decomposition:
- Package vga_pkg holds:
  - the timing constants HBP=216, HFP=1016, VBP=27, VFP=627.
  - COLOR_W and the piece_desc_t struct (en, x0, y0, x1, y1, color).
  - the background colour constant.
- Sub-module vga_piece_hit: combinational rectangle test for one descriptor, outputting hit and edge. It is instantiated NPIECE times in S2.

Test Plan:
- Reset values: hold clr=0 for 2 cycles with vidon=1 -> rgb=0, hsync_out=0, vsync_out=0, frame_commit=0, wr_ready=1.
- Single piece at frame start:
  - Setup: write piece0 en=1, (10,20)-(19,29), color 12'hF00; toggle vsync_in 1->0.
  - frame_commit pulses once.
  - Then hc=227, vc=48, vidon=1 -> rgb=12'hF00 exactly 3 cycles later.
  - hc=226 -> BG_COLOR.
- Priority: piece0 (0,0)-(99,99) 12'h00F and piece3 (50,50)-(149,149) 12'h0F0.
  - Pixel (60,60) -> 12'h00F.
  - Pixel (120,120) -> 12'h0F0.
  - Pixel (200,200) -> 12'h000.
- Tear-free update: write a new colour for piece0 mid-frame (vc=300) -> old colour persists until the next vsync fall, then the new colour appears. A second vsync fall with no writes gives no frame_commit.
- Handshake boundary: hold wr_valid during the vsync_fall cycle -> wr_ready=0 that cycle and the write lands the following cycle in shadow only. A write with wr_idx=7 is dropped.
- Blank and edge cases:
  - vidon=0 inside a piece region -> rgb=0.
  - hsync_in pattern appears on hsync_out delayed exactly 3 cycles.
  - Piece with x0=50, x1=40 never hits.
  - With VGA_PIECE_BORDER_EN, pixel (10,25) of piece0 (12'hF00) -> 12'h0FF.
